alu_seq_ctrl: RTL and testbench

- Moore FSM that sequences the register-file / shifter / ALU datapath for one 16-bit instruction at a time.
- Decodes the opcode, steps the register reads, the ALU evaluation and the writeback or status load.
- Exposes a start/wait handshake to the instruction source.
- Sits between the instruction register and the datapath control pins.

---
 rtl/alu_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: Moore sequencer for a 16-bit register/shifter/ALU datapath.
// Optional retired-instruction counter enabled by SEQ_RETIRE_CNT_EN.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   s            start request (sampled in WAIT only)
//   instr        held instruction
//   w            idle / ready for s
//   nsel         one-hot reg select (001 Rn, 010 Rd, 100 Rm)
//   loada/b/c/s  datapath register loads
//   asel, bsel   ALU operand muxes
//   vsel, write  writeback mux and register-file write
//   alu_op       00 ADD, 01 SUB, 10 AND, 11 NOT B
//   shift        shifter control, instr[4:3]
//   illegal      sticky undecodable-opcode flag
//   retired_cnt  retired count (SEQ_RETIRE_CNT_EN only)
module alu_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic [15:0]      instr,
  output logic             w,
  output logic [2:0]       nsel,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic             vsel,
  output logic             write,
  output logic [1:0]       alu_op,
  output logic [1:0]       shift,
`ifdef SEQ_RETIRE_CNT_EN
  output logic [CNT_W-1:0] retired_cnt,
`endif
  output logic             illegal
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GETA,
    S_GETB,
    S_EXEC,
    S_STAT,
    S_WREG,
    S_WIMM
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [2:0] w_opc;
  logic [1:0] w_op;
  logic       w_movi;
  logic       w_movr;
  logic       w_alu;
  logic       w_mvn;
  logic       w_3op;
  logic       w_cmp;
  logic       w_set_ill;

  logic       r_w;
  logic [2:0] r_nsel;
  logic       r_loada;
  logic       r_loadb;
  logic       r_loadc;
  logic       r_loads;
  logic       r_asel;
  logic       r_vsel;
  logic       r_write;
  logic [1:0] r_alu_op;
  logic [1:0] r_shift;
  logic       r_ill;

  logic       w_n_w;
  logic [2:0] w_n_nsel;
  logic       w_n_loada;
  logic       w_n_loadb;
  logic       w_n_loadc;
  logic       w_n_loads;
  logic       w_n_asel;
  logic       w_n_vsel;
  logic       w_n_write;
  logic [1:0] w_n_alu_op;
  logic [1:0] w_n_shift;

  // register addresses are consumed by the datapath, not here
  logic w_unused_bits;
  assign w_unused_bits = ^{instr[10:5], instr[2:0]};

  assign w_opc  = instr[15:13];
  assign w_op   = instr[12:11];
  assign w_movi = (w_opc == 3'b110) && (w_op == 2'b10);
  assign w_movr = (w_opc == 3'b110) && (w_op == 2'b00);
  assign w_alu  = (w_opc == 3'b101);
  assign w_mvn  = w_alu && (w_op == 2'b11);
  assign w_3op  = w_alu && (w_op != 2'b11);
  assign w_cmp  = w_alu && (w_op == 2'b01);

  always_comb begin
    w_nxt     = r_state;
    w_set_ill = 1'b0;
    unique case (r_state)
      S_WAIT:   if (s) w_nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          w_movi:          w_nxt = S_WIMM;
          (w_movr | w_mvn): w_nxt = S_GETB;
          w_3op:           w_nxt = S_GETA;
          default: begin
            w_nxt     = S_WAIT;
            w_set_ill = 1'b1;
          end
        endcase
      end
      S_GETA:   w_nxt = S_GETB;
      S_GETB:   w_nxt = S_EXEC;
      S_EXEC:   w_nxt = w_cmp ? S_STAT : S_WREG;
      S_STAT:   w_nxt = S_WAIT;
      S_WREG:   w_nxt = S_WAIT;
      S_WIMM:   w_nxt = S_WAIT;
      default:  w_nxt = S_WAIT;
    endcase
  end

  // outputs are decoded from the next state and registered, so they
  // line up exactly with the state they belong to
  always_comb begin
    w_n_w      = 1'b0;
    w_n_nsel   = 3'b000;
    w_n_loada  = 1'b0;
    w_n_loadb  = 1'b0;
    w_n_loadc  = 1'b0;
    w_n_loads  = 1'b0;
    w_n_asel   = 1'b0;
    w_n_vsel   = 1'b0;
    w_n_write  = 1'b0;
    w_n_alu_op = 2'b00;
    w_n_shift  = 2'b00;
    unique case (w_nxt)
      S_WAIT:   w_n_w = 1'b1;
      S_DECODE: w_n_w = 1'b0;
      S_GETA: begin
        w_n_nsel  = 3'b001;
        w_n_loada = 1'b1;
      end
      S_GETB: begin
        w_n_nsel  = 3'b100;
        w_n_loadb = 1'b1;
      end
      S_EXEC: begin
        w_n_loadc  = 1'b1;
        w_n_asel   = w_movr;
        w_n_alu_op = w_movr ? 2'b00 : w_op;
        w_n_shift  = instr[4:3];
      end
      S_STAT: begin
        w_n_alu_op = 2'b01;
        w_n_loads  = 1'b1;
      end
      S_WREG: begin
        w_n_nsel  = 3'b010;
        w_n_write = 1'b1;
      end
      S_WIMM: begin
        w_n_nsel  = 3'b001;
        w_n_vsel  = 1'b1;
        w_n_write = 1'b1;
      end
      default: w_n_w = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_WAIT;
      r_w      <= 1'b1;
      r_nsel   <= 3'b000;
      r_loada  <= 1'b0;
      r_loadb  <= 1'b0;
      r_loadc  <= 1'b0;
      r_loads  <= 1'b0;
      r_asel   <= 1'b0;
      r_vsel   <= 1'b0;
      r_write  <= 1'b0;
      r_alu_op <= 2'b00;
      r_shift  <= 2'b00;
      r_ill    <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_w      <= w_n_w;
      r_nsel   <= w_n_nsel;
      r_loada  <= w_n_loada;
      r_loadb  <= w_n_loadb;
      r_loadc  <= w_n_loadc;
      r_loads  <= w_n_loads;
      r_asel   <= w_n_asel;
      r_vsel   <= w_n_vsel;
      r_write  <= w_n_write;
      r_alu_op <= w_n_alu_op;
      r_shift  <= w_n_shift;
      if (r_state == S_WAIT && s)
        r_ill <= 1'b0;
      else if (w_set_ill)
        r_ill <= 1'b1;
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;

  assign w_retire = (w_nxt == S_WAIT) &&
                    ((r_state == S_WREG) ||
                     (r_state == S_WIMM) ||
                     (r_state == S_STAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (w_retire)
      r_cnt <= r_cnt + 1'b1;
  end

  assign retired_cnt = r_cnt;
`endif

  assign w      = r_w;
  assign nsel   = r_nsel;
  assign loada  = r_loada;
  assign loadb  = r_loadb;
  assign loadc  = r_loadc;
  assign loads  = r_loads;
  assign asel   = r_asel;
  assign bsel   = 1'b0;
  assign vsel   = r_vsel;
  assign write  = r_write;
  assign alu_op = r_alu_op;
  assign shift  = r_shift;
  assign illegal = r_ill;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: table-driven scoreboard bench for alu_seq_ctrl.
// Each sampled cycle is compared as one packed control word.
module tb_alu_seq_ctrl;

  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic [2:0]  nsel;
  logic        loada, loadb, loadc, loads;
  logic        asel, bsel, vsel, write;
  logic [1:0]  alu_op, shift;
  logic        illegal;
`ifdef SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s(s),
    .instr(instr),
    .w(w),
    .nsel(nsel),
    .loada(loada),
    .loadb(loadb),
    .loadc(loadc),
    .loads(loads),
    .asel(asel),
    .bsel(bsel),
    .vsel(vsel),
    .write(write),
    .alu_op(alu_op),
    .shift(shift),
`ifdef SEQ_RETIRE_CNT_EN
    .retired_cnt(retired_cnt),
`endif
    .illegal(illegal)
  );

  // {illegal, w, nsel, la, lb, lc, ls, asel, bsel, vsel, write, op, sh}
  typedef logic [16:0] word_t;

  function automatic word_t cw(
    input logic il, input logic wv, input logic [2:0] ns,
    input logic la, input logic lb, input logic lc,
    input logic ls, input logic as, input logic vs,
    input logic wr, input logic [1:0] op,
    input logic [1:0] sh);
    return {il, wv, ns, la, lb, lc, ls, as, 1'b0,
            vs, wr, op, sh};
  endfunction

  function automatic word_t act();
    return {illegal, w, nsel, loada, loadb, loadc, loads,
            asel, bsel, vsel, write, alu_op, shift};
  endfunction

  typedef struct {
    logic [15:0]      ins;
    int               n;
    logic [4:0][16:0] seq;
    logic [16:0]      fin;
    bit               ret;
  } vec_t;

  vec_t tv[10];
  word_t q[$];

  word_t WT, WI, DC, GA, GB, WR, WM;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (w !== 1'b1 && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    if (k >= 20) chk("idle_timeout", 32'(w), 32'd1);
  endtask

  task automatic run(input string nm, input vec_t v);
    word_t e;
    int k;
    wait_idle();
    instr = v.ins;
    s = 1'b1;
    for (int i = 0; i < v.n; i++) q.push_back(v.seq[i]);
    q.push_back(v.fin);
    k = 0;
    while (q.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      s = 1'b0;
      e = q.pop_front();
      chk($sformatf("%s_c%0d", nm, k), 32'(act()), 32'(e));
      k++;
    end
    if (v.ret) exp_cnt++;
`ifdef SEQ_RETIRE_CNT_EN
    chk({nm, "_cnt"}, 32'(retired_cnt), exp_cnt);
`endif
  endtask

  initial begin
    WT = cw(0,1,3'b000,0,0,0,0,0,0,0,2'b00,2'b00);
    WI = cw(1,1,3'b000,0,0,0,0,0,0,0,2'b00,2'b00);
    DC = cw(0,0,3'b000,0,0,0,0,0,0,0,2'b00,2'b00);
    GA = cw(0,0,3'b001,1,0,0,0,0,0,0,2'b00,2'b00);
    GB = cw(0,0,3'b100,0,1,0,0,0,0,0,2'b00,2'b00);
    WR = cw(0,0,3'b010,0,0,0,0,0,0,1,2'b00,2'b00);
    WM = cw(0,0,3'b001,0,0,0,0,0,1,1,2'b00,2'b00);

    // MOVI R2,#7
    tv[0] = '{16'hD207, 2, '0, WT, 1};
    tv[0].seq[0] = DC; tv[0].seq[1] = WM;
    // ADD R5,R1,R2
    tv[1] = '{16'hA1A2, 5, '0, WT, 1};
    tv[1].seq[0] = DC; tv[1].seq[1] = GA; tv[1].seq[2] = GB;
    tv[1].seq[3] = cw(0,0,0,0,0,1,0,0,0,0,2'b00,2'b00);
    tv[1].seq[4] = WR;
    // CMP R1,R2
    tv[2] = '{16'hA902, 5, '0, WT, 1};
    tv[2].seq[0] = DC; tv[2].seq[1] = GA; tv[2].seq[2] = GB;
    tv[2].seq[3] = cw(0,0,0,0,0,1,0,0,0,0,2'b01,2'b00);
    tv[2].seq[4] = cw(0,0,0,0,0,0,1,0,0,0,2'b01,2'b00);
    // MVN R5,R3
    tv[3] = '{16'hB8A3, 4, '0, WT, 1};
    tv[3].seq[0] = DC; tv[3].seq[1] = GB;
    tv[3].seq[2] = cw(0,0,0,0,0,1,0,0,0,0,2'b11,2'b00);
    tv[3].seq[3] = WR;
    // MOVR
    tv[4] = '{16'hC0A3, 4, '0, WT, 1};
    tv[4].seq[0] = DC; tv[4].seq[1] = GB;
    tv[4].seq[2] = cw(0,0,0,0,0,1,0,1,0,0,2'b00,2'b00);
    tv[4].seq[3] = WR;
    // ADD with shift=11
    tv[5] = '{16'hA1BA, 5, '0, WT, 1};
    tv[5].seq[0] = DC; tv[5].seq[1] = GA; tv[5].seq[2] = GB;
    tv[5].seq[3] = cw(0,0,0,0,0,1,0,0,0,0,2'b00,2'b11);
    tv[5].seq[4] = WR;
    // AND with shift=01
    tv[6] = '{16'hB00A, 5, '0, WT, 1};
    tv[6].seq[0] = DC; tv[6].seq[1] = GA; tv[6].seq[2] = GB;
    tv[6].seq[3] = cw(0,0,0,0,0,1,0,0,0,0,2'b10,2'b01);
    tv[6].seq[4] = WR;
    // illegal opcode 111
    tv[7] = '{16'hE000, 1, '0, WI, 0};
    tv[7].seq[0] = DC;
    // illegal 110/01, flag cleared then set again
    tv[8] = '{16'hC800, 1, '0, WI, 0};
    tv[8].seq[0] = DC;
    // legal start clears illegal
    tv[9] = '{16'hD207, 2, '0, WT, 1};
    tv[9].seq[0] = DC; tv[9].seq[1] = WM;

    rst_n = 1'b0;
    s     = 1'b0;
    instr = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    chk("reset_word", 32'(act()), 32'(WT));
`ifdef SEQ_RETIRE_CNT_EN
    chk("reset_cnt", 32'(retired_cnt), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset", 32'(act()), 32'(WT));

    for (int i = 0; i < 10; i++)
      run($sformatf("v%0d", i), tv[i]);

    // s held high: exactly one WAIT cycle between instructions
    wait_idle();
    instr = 16'hD207;
    s = 1'b1;
    q.push_back(DC); q.push_back(WM); q.push_back(WT);
    q.push_back(DC); q.push_back(WM); q.push_back(WT);
    for (int k = 0; k < 6; k++) begin
      word_t e;
      @(posedge clk);
      @(negedge clk);
      if (k == 3) s = 1'b0;
      e = q.pop_front();
      chk($sformatf("b2b_c%0d", k), 32'(act()), 32'(e));
    end
    exp_cnt += 2;
`ifdef SEQ_RETIRE_CNT_EN
    chk("b2b_cnt", 32'(retired_cnt), exp_cnt);
`endif

    // async reset in GETB of ADD aborts with no write/loads
    wait_idle();
    instr = 16'hA1A2;
    s = 1'b1;
    @(posedge clk); @(negedge clk); s = 1'b0;
    chk("abort_dec", 32'(act()), 32'(DC));
    @(posedge clk); @(negedge clk);
    chk("abort_geta", 32'(act()), 32'(GA));
    @(posedge clk); @(negedge clk);
    chk("abort_getb", 32'(act()), 32'(GB));
    rst_n = 1'b0;
    #1;
    chk("abort_w", 32'(w), 32'd1);
    chk("abort_word", 32'(act()), 32'(WT));
    exp_cnt = 0;
`ifdef SEQ_RETIRE_CNT_EN
    chk("abort_cnt", 32'(retired_cnt), exp_cnt);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("abort_idle%0d", k), 32'(act()), 32'(WT));
    end

    // a final retire after reset restarts the count from zero
    run("post_abort", tv[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
